silly_voice_allocator: RTL
==========================

# silly_voice_allocator

Polyphonic voice scheduler for the silly synthesizer. Watches the 13 piano-key lines coming off the breakout board and shares a fixed pool of oscillator voices between them. Each press is assigned to a free voice, or to the oldest voice when none is free. Outputs per-voice gate, note index and a one-cycle retrigger pulse, which drive the oscillator/mixer datapath ahead of the PWM output.

## Interface
- NUM_KEYS, 13: number of key requesters. Bit i is note i, and lower i wins priority.
- NUM_VOICES, 4: number of oscillator voices shared (≥2).
- NOTE_W, $clog2(NUM_KEYS) = 4: width of a note index.
- clk  input  1  system clock.
- nrst  input  1  reset, asynchronous, active-low. Fed from the wrapper's synchronized gated reset.
- en  input  1  allocator enable. Low = all-notes-off (synchronous).
- keys  input  NUM_KEYS  key levels, already synchronized to clk. 1 = held.
- voice_gate  output  NUM_VOICES  voice v is sounding.
- voice_note  output  NUM_VOICES×NOTE_W  note index owned by voice v.
- voice_trig  output  NUM_VOICES  one-cycle pulse when voice v receives a new note.
- steal  output  1  one-cycle pulse when the current allocation evicted an active voice.

## Operation
- State: keys_q (previous keys), pending[NUM_KEYS], per-voice gate/note, and per-voice age rank (log2 NUM_VOICES bits).
- Ranks always form a permutation of 0..NUM_VOICES-1. Rank 0 is the newest voice. Reset rank of voice v = v.
- Press edge (keys[i]=1, keys_q[i]=0, en=1): set pending[i].
- Release edge (keys[i]=0, keys_q[i]=1): clear pending[i], and clear the gate of any voice with gate=1 and note=i.
- Allocation, at most one per cycle, when any pending bit is set and en=1:
  - Note = lowest-index pending key.
  - Target = lowest-index voice with gate=0, using registered gate values.
  - If no voice has gate=0, target = the voice with rank NUM_VOICES-1, and steal pulses.
  - Target gets gate=1, note=i and trig=1. pending[i] is cleared.
  - Rank update: every voice whose rank is less than the target's old rank increments, then the target's rank becomes 0.
- A voice freed by a release in the same cycle is not eligible until the next cycle.
- If the steal target is released in the same cycle as it is stolen, allocation wins: gate=1, new note, trig=1.
- A stolen note's key stays held with no voice. Its later release matches no voice and has no effect.
- A press and release of the same key in the same cycle is impossible, since it is a single level.
- en=0:
  - All gates clear, pending clears, no trig or steal.
  - keys_q still tracks keys, so keys held through en rising are not re-pressed.
  - Ranks hold their values.

## Timing
- Reset values: voice_gate=0, voice_note=0, voice_trig=0, steal=0, pending=0, keys_q=0, rank[v]=v.
- Press latency: key first sampled high in cycle N → pending set end of N → allocated end of N+1. gate, note and trig are visible in cycle N+2.
- trig and steal are high for exactly one cycle.
- Queued presses drain one per cycle in ascending key order.
- Release latency: key first sampled low in cycle N → gate low in cycle N+1.
- Reset mid-operation: all state returns to reset values immediately. No trig is generated on reset exit.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package silly_synth_pkg:
  - NUM_KEYS and NUM_VOICES constants.
  - note_t (logic [NOTE_W-1:0]) and rank_t typedefs.
- Sub-module silly_prio_enc, parameterized width: lowest-set-bit index plus valid flag.
  - Instantiated once for pending keys and once for free voices (~NUM_VOICES bits).
- Everything else (edge detect, voice registers, rank update) lives in a single always_ff plus combinational next-state logic.

## Test plan
- Single press: key 5 high from cycle 10 → voice 0 gate=1, note=5, trig pulses in cycle 12. Key 5 low at cycle 20 → voice 0 gate=0 at cycle 21.
- Chord: keys 0, 3 and 7 rise in the same cycle N → voices 0, 1 and 2 get notes 0, 3 and 7. Their trigs appear in cycles N+2, N+3 and N+4.
- Steal:
  - Press keys 1, 2, 3, 4 one at a time, 5 cycles apart.
  - Then press key 9 → voice 0 (oldest) gets note 9, with trig and steal pulsing together.
  - Next press of key 10 steals voice 1.
- Release and alloc collision:
  - All 4 voices busy.
  - Release the oldest voice's note in the same cycle key 11 is allocated → that voice ends with gate=1, note=11, steal=1.
- Release while pending: 6 keys pressed together, and the highest key is released before it is serviced → it is never allocated, and no trig appears for it.
- en and reset:
  - en=0 while 3 voices are active → all gates 0 next cycle.
  - en=1 with keys still held → no trig.
  - Assert nrst mid-queue → all outputs 0 and ranks 0..3 immediately.

Source files
------------

// File: rtl/silly_synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : silly_synth_pkg
//  Brief    : Shared sizes and types for the silly synthesizer voice logic.
//  Revision : 1.0  initial release
// ============================================================================
package silly_synth_pkg;

    localparam int NUM_KEYS   = 13;
    localparam int NUM_VOICES = 4;
    localparam int NOTE_W     = $clog2(NUM_KEYS);
    localparam int RANK_W     = $clog2(NUM_VOICES);

    typedef logic [NOTE_W-1:0] note_t;
    typedef logic [RANK_W-1:0] rank_t;
    typedef logic [RANK_W-1:0] voice_t;

endpackage
`default_nettype wire

// File: rtl/silly_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : silly_prio_enc
//  Brief    : Lowest-set-bit priority encoder with a valid flag.
//  Revision : 1.0  initial release
// ============================================================================
module silly_prio_enc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/silly_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : silly_voice_allocator
//  Brief    : Shares a pool of oscillator voices among the piano keys,
//             stealing the oldest voice when none is free.
//  Revision : 1.0  initial release
// ============================================================================
module silly_voice_allocator
    import silly_synth_pkg::*;
(
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         en,
    input  logic [NUM_KEYS-1:0]          keys,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_trig,
    output logic                         steal
);

    logic [NUM_KEYS-1:0]   r_keys_q;
    logic [NUM_KEYS-1:0]   r_pending;
    logic [NUM_VOICES-1:0] r_gate;
    note_t                 r_note [NUM_VOICES];
    rank_t                 r_rank [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_trig;
    logic                  r_steal;

    logic [NUM_KEYS-1:0]   w_rise;
    logic [NUM_KEYS-1:0]   w_fall;
    logic [NUM_KEYS-1:0]   w_pend_req;
    note_t                 w_alloc_note;
    logic                  w_alloc_valid;
    voice_t                w_free_idx;
    logic                  w_free_valid;
    voice_t                w_oldest;
    voice_t                w_target;
    rank_t                 w_tgt_rank;

    logic [NUM_KEYS-1:0]   w_pending_nx;
    logic [NUM_VOICES-1:0] w_gate_nx;
    note_t                 w_note_nx [NUM_VOICES];
    rank_t                 w_rank_nx [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_trig_nx;
    logic                  w_steal_nx;

    assign w_rise     = keys & ~r_keys_q;
    assign w_fall     = ~keys & r_keys_q;
    // A key let go this cycle must not be granted a voice.
    assign w_pend_req = r_pending & ~w_fall;

    silly_prio_enc #(
        .WIDTH (NUM_KEYS),
        .IDX_W (NOTE_W)
    ) u_key_enc (
        .req   (w_pend_req),
        .idx   (w_alloc_note),
        .valid (w_alloc_valid)
    );

    silly_prio_enc #(
        .WIDTH (NUM_VOICES),
        .IDX_W (RANK_W)
    ) u_voice_enc (
        .req   (~r_gate),
        .idx   (w_free_idx),
        .valid (w_free_valid)
    );

    always_comb begin
        w_oldest = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_rank[v] == rank_t'(NUM_VOICES - 1)) begin
                w_oldest = voice_t'(v);
            end
        end
    end

    assign w_target   = w_free_valid ? w_free_idx : w_oldest;
    assign w_tgt_rank = r_rank[w_target];

    always_comb begin
        w_pending_nx = (r_pending | w_rise) & ~w_fall;
        w_gate_nx    = r_gate;
        w_note_nx    = r_note;
        w_rank_nx    = r_rank;
        w_trig_nx    = '0;
        w_steal_nx   = 1'b0;

        for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_gate[v] && w_fall[r_note[v]]) begin
                w_gate_nx[v] = 1'b0;
            end
        end

        if (!en) begin
            w_pending_nx = '0;
            w_gate_nx    = '0;
        end else if (w_alloc_valid) begin
            // Allocation is applied after the release clear so it wins a collision.
            w_pending_nx[w_alloc_note] = 1'b0;
            w_gate_nx[w_target]        = 1'b1;
            w_note_nx[w_target]        = w_alloc_note;
            w_trig_nx[w_target]        = 1'b1;
            w_steal_nx                 = ~w_free_valid;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (voice_t'(v) == w_target) begin
                    w_rank_nx[v] = '0;
                end else if (r_rank[v] < w_tgt_rank) begin
                    w_rank_nx[v] = rank_t'(r_rank[v] + 1'b1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_keys_q  <= '0;
            r_pending <= '0;
            r_gate    <= '0;
            r_trig    <= '0;
            r_steal   <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_note[v] <= '0;
                r_rank[v] <= rank_t'(v);
            end
        end else begin
            r_keys_q  <= keys;
            r_pending <= w_pending_nx;
            r_gate    <= w_gate_nx;
            r_trig    <= w_trig_nx;
            r_steal   <= w_steal_nx;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_note[v] <= w_note_nx[v];
                r_rank[v] <= w_rank_nx[v];
            end
        end
    end

    assign voice_gate = r_gate;
    assign voice_trig = r_trig;
    assign steal      = r_steal;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_note
        assign voice_note[v*NOTE_W +: NOTE_W] = r_note[v];
    end

endmodule
`default_nettype wire
